// File: rtl/demux_1_2_stream.sv
// demux_1_2_stream
// Registered 1-to-2 stream demultiplexer. One input word per handshake is
// steered by its select bit s into one of two output channels. Each output
// channel owns a 2-entry FIFO, so a stalled consumer only back-pressures
// words that are addressed to it.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset
//   i_valid / i_ready   input handshake
//   i_data [DW]         input word
//   s                   destination select (0 -> output 0, 1 -> output 1)
//   y0_valid / y0_ready output 0 handshake, y0_data [DW] head word
//   y1_valid / y1_ready output 1 handshake, y1_data [DW] head word
//   cnt0 / cnt1 [CW]    words delivered per output, wraps modulo 2^CW
module demux_1_2_stream #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    input  logic          s,
    output logic          y0_valid,
    input  logic          y0_ready,
    output logic [DW-1:0] y0_data,
    output logic          y1_valid,
    input  logic          y1_ready,
    output logic [DW-1:0] y1_data,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic [DW-1:0] mem [2][2];
    logic [1:0]    occ [2];
    logic [CW-1:0] cnt [2];
    logic [1:0]    rd_ptr;
    logic [1:0]    wr_ptr;
    logic [1:0]    y_rdy;
    logic [1:0]    y_vld;
    logic [1:0]    deliver;
    logic [1:0]    wr_en;
    logic          accept;

    assign y_rdy = {y1_ready, y0_ready};

    always_comb begin
        y_vld   = 2'b00;
        deliver = 2'b00;
        wr_en   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            y_vld[k]   = (occ[k] != 2'd0);
            deliver[k] = y_vld[k] & y_rdy[k];
        end
        // A full FIFO still takes a word when its head leaves this cycle.
        i_ready  = (occ[s] != 2'd2) | deliver[s];
        accept   = i_valid & i_ready;
        wr_en[s] = accept;
    end

    // Control state: occupancy, pointers and delivery counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                occ[k] <= 2'd0;
                cnt[k] <= '0;
            end
            rd_ptr <= 2'b00;
            wr_ptr <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k]) begin
                    wr_ptr[k] <= ~wr_ptr[k];
                end
                if (deliver[k]) begin
                    rd_ptr[k] <= ~rd_ptr[k];
                    cnt[k]    <= cnt[k] + CW'(1);
                end
                occ[k] <= occ[k] + {1'b0, wr_en[k]} - {1'b0, deliver[k]};
            end
        end
    end

    // Entry storage; stale contents are harmless because occupancy gates them.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr_en[k]) begin
                mem[k][wr_ptr[k]] <= i_data;
            end
        end
    end

    // Head words are forced to zero while a channel is empty so the data
    // outputs read 0 after reset without resetting the storage.
    assign y0_valid = y_vld[0];
    assign y1_valid = y_vld[1];
    assign y0_data  = y_vld[0] ? mem[0][rd_ptr[0]] : '0;
    assign y1_data  = y_vld[1] ? mem[1][rd_ptr[1]] : '0;
    assign cnt0     = cnt[0];
    assign cnt1     = cnt[1];

endmodule

// File: tb/tb_demux_1_2_stream.sv
module tb_demux_1_2_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          s;
    logic          y0_valid;
    logic          y0_ready;
    logic [DW-1:0] y0_data;
    logic          y1_valid;
    logic          y1_ready;
    logic [DW-1:0] y1_data;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int checks   = 0;
    int failures = 0;

    demux_1_2_stream #(.DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .s        (s),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y0_data  (y0_data),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .y1_data  (y1_data),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    // Producer protocol monitor: s and i_data must hold while stalled.
    logic          prev_stall = 1'b0;
    logic          prev_s     = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(posedge clk) begin
        if (rst_n && prev_stall && i_valid) begin
            chk("proto_s_hold", {31'd0, s}, {31'd0, prev_s});
            chk("proto_data_hold", {24'd0, i_data}, {24'd0, prev_data});
        end
        prev_stall = rst_n & i_valid & ~i_ready;
        prev_s     = s;
        prev_data  = i_data;
    end

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        s        = 1'b0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        settle();

        // Reset state
        chk("rst_y0_valid", {31'd0, y0_valid}, 32'd0);
        chk("rst_y1_valid", {31'd0, y1_valid}, 32'd0);
        chk("rst_cnt0", {28'd0, cnt0}, 32'd0);
        chk("rst_cnt1", {28'd0, cnt1}, 32'd0);
        chk("rst_y0_data", {24'd0, y0_data}, 32'd0);
        chk("rst_y1_data", {24'd0, y1_data}, 32'd0);
        s = 1'b0; settle();
        chk("rst_iready_s0", {31'd0, i_ready}, 32'd1);
        s = 1'b1; settle();
        chk("rst_iready_s1", {31'd0, i_ready}, 32'd1);

        // One word to each output, consumers ready
        y0_ready = 1'b1; y1_ready = 1'b1;
        i_valid = 1'b1; s = 1'b0; i_data = 8'hA1; settle();
        chk("t2_iready_a1", {31'd0, i_ready}, 32'd1);
        tick();
        s = 1'b1; i_data = 8'hB2; settle();
        chk("t2_y0_valid", {31'd0, y0_valid}, 32'd1);
        chk("t2_y0_data", {24'd0, y0_data}, 32'hA1);
        chk("t2_iready_b2", {31'd0, i_ready}, 32'd1);
        tick();
        i_valid = 1'b0; settle();
        chk("t2_y1_valid", {31'd0, y1_valid}, 32'd1);
        chk("t2_y1_data", {24'd0, y1_data}, 32'hB2);
        chk("t2_y0_empty", {31'd0, y0_valid}, 32'd0);
        tick();
        chk("t2_cnt0", {28'd0, cnt0}, 32'd1);
        chk("t2_cnt1", {28'd0, cnt1}, 32'd1);
        chk("t2_y1_empty", {31'd0, y1_valid}, 32'd0);

        // Output 0 stalled: back-pressure on s=0 only
        y0_ready = 1'b0;
        i_valid = 1'b1; s = 1'b0; i_data = 8'h11; tick();
        i_data = 8'h22; tick();
        i_data = 8'h33; settle();
        chk("t3_iready_33", {31'd0, i_ready}, 32'd0);
        chk("t3_head_11", {24'd0, y0_data}, 32'h11);
        tick();
        chk("t3_iready_33_hold", {31'd0, i_ready}, 32'd0);
        i_valid = 1'b0; tick();
        i_valid = 1'b1; s = 1'b1; i_data = 8'h5C; settle();
        chk("t3_iready_s1", {31'd0, i_ready}, 32'd1);
        tick();
        i_valid = 1'b0; settle();
        chk("t3_y1_data", {24'd0, y1_data}, 32'h5C);
        chk("t3_y1_valid", {31'd0, y1_valid}, 32'd1);
        tick();
        chk("t3_cnt1", {28'd0, cnt1}, 32'd2);
        chk("t3_y0_still_11", {24'd0, y0_data}, 32'h11);
        y0_ready = 1'b1; i_valid = 1'b1; s = 1'b0; i_data = 8'h33; settle();
        chk("t3_iready_passthru", {31'd0, i_ready}, 32'd1);
        tick();
        i_valid = 1'b0; settle();
        chk("t3_order_22", {24'd0, y0_data}, 32'h22);
        tick();
        chk("t3_order_33", {24'd0, y0_data}, 32'h33);
        tick();
        chk("t3_y0_drained", {31'd0, y0_valid}, 32'd0);
        chk("t3_cnt0", {28'd0, cnt0}, 32'd4);

        // Full FIFO with pass-through: 10 back-to-back words
        y0_ready = 1'b0;
        i_valid = 1'b1; s = 1'b0; i_data = 8'h40; tick();
        i_data = 8'h41; tick();
        y0_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            i_data = 8'h42 + 8'(j); settle();
            chk("t4_iready_full", {31'd0, i_ready}, 32'd1);
            chk("t4_valid", {31'd0, y0_valid}, 32'd1);
            chk("t4_head", {24'd0, y0_data}, 32'h40 + 32'(j));
            tick();
        end
        i_valid = 1'b0; settle();
        chk("t4_head_4a", {24'd0, y0_data}, 32'h4A);
        tick();
        chk("t4_head_4b", {24'd0, y0_data}, 32'h4B);
        tick();
        chk("t4_empty", {31'd0, y0_valid}, 32'd0);
        chk("t4_cnt0_wrap", {28'd0, cnt0}, 32'd0);
        chk("t4_cnt1", {28'd0, cnt1}, 32'd2);

        // Reset with both FIFOs holding two words
        y0_ready = 1'b0; y1_ready = 1'b0;
        i_valid = 1'b1; s = 1'b0; i_data = 8'h60; tick();
        i_data = 8'h61; tick();
        s = 1'b1; i_data = 8'h70; tick();
        i_data = 8'h71; tick();
        i_valid = 1'b0; settle();
        chk("t5_y0_full_valid", {31'd0, y0_valid}, 32'd1);
        chk("t5_y1_full_valid", {31'd0, y1_valid}, 32'd1);
        rst_n = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
        i_valid = 1'b1; s = 1'b0; i_data = 8'hEE;
        tick();
        rst_n = 1'b1; i_valid = 1'b0; settle();
        chk("t5_y0_valid", {31'd0, y0_valid}, 32'd0);
        chk("t5_y1_valid", {31'd0, y1_valid}, 32'd0);
        chk("t5_cnt0", {28'd0, cnt0}, 32'd0);
        chk("t5_cnt1", {28'd0, cnt1}, 32'd0);
        chk("t5_y0_data", {24'd0, y0_data}, 32'd0);
        i_valid = 1'b1; s = 1'b1; i_data = 8'h99; tick();
        i_valid = 1'b0; settle();
        chk("t5_post_data", {24'd0, y1_data}, 32'h99);
        tick();
        chk("t5_post_cnt1", {28'd0, cnt1}, 32'd1);
        chk("t5_post_cnt0", {28'd0, cnt0}, 32'd0);

        // Counter wrap at CW=4: 17 deliveries on output 1
        rst_n = 1'b0; tick();
        rst_n = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1; s = 1'b1;
        for (int i = 0; i < 18; i++) begin
            i_valid = (i < 17);
            i_data  = 8'h80 + 8'(i);
            tick();
            if (i == 15) chk("t6_cnt1_15", {28'd0, cnt1}, 32'd15);
            if (i == 16) chk("t6_cnt1_16", {28'd0, cnt1}, 32'd0);
            if (i == 17) chk("t6_cnt1_17", {28'd0, cnt1}, 32'd1);
        end
        i_valid = 1'b0; settle();
        chk("t6_cnt0", {28'd0, cnt0}, 32'd0);
        chk("t6_y1_empty", {31'd0, y1_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
